temp_result_avg: RTL and testbench

TEMP_RESULT_AVG -- requirements
Module: temp_result_avg

---
 rtl/temp_result_avg.sv | 152 +++++++++++++++
 tb/tb_temp_result_avg.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/temp_result_avg.sv
// temp_result_avg: averages 2**AVG_LOG2 edge-captured {ib,ibf} samples and presents the result through a
// valid/ready output register with sticky overrun. Define TEMP_AVG_MINMAX_EN to add per-window min_o/max_o.
module temp_result_avg #(
  parameter int AVG_LOG2 = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [7:0]  ib,
  input  logic [7:0]  ibf,
  input  logic        valid_in,
  input  logic        clr,
  input  logic        out_ready,
  output logic [15:0] avg_o,
  output logic        avg_valid,
  output logic [4:0]  sample_cnt,
  output logic        overrun
`ifdef TEMP_AVG_MINMAX_EN
  ,
  output logic [15:0] min_o,
  output logic [15:0] max_o
`endif
);

  localparam int         AW       = 16 + AVG_LOG2;
  localparam logic [4:0] CNT_LAST = 5'((1 << AVG_LOG2) - 1);

  typedef enum logic {S_IDLE, S_ACCUM} state_t;

  state_t          r_state, w_state_nxt;
  logic            r_vin_d;
  logic [AW-1:0]   r_acc, w_acc_nxt, w_sum;
  logic [4:0]      r_cnt, w_cnt_nxt;
  logic [15:0]     r_avg;
  logic            r_avg_valid;
  logic            r_ovr;
  logic [15:0]     w_sample;
  logic            w_cap, w_last, w_load, w_xfer;

  assign w_sample = {ib, ibf};
  // A capture landing in a clr cycle is dropped; the edge register still tracks valid_in.
  assign w_cap    = valid_in & ~r_vin_d & ~clr;
  assign w_last   = (r_cnt == CNT_LAST);
  assign w_load   = w_cap & w_last;
  assign w_xfer   = r_avg_valid & out_ready;
  assign w_sum    = r_acc + AW'(w_sample);

  // Resets high so a valid_in already asserted at reset release is not seen as an edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_vin_d <= 1'b1;
    else          r_vin_d <= valid_in;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_acc   <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_acc   <= w_acc_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_acc_nxt   = r_acc;
    w_cnt_nxt   = r_cnt;
    if (clr) begin
      w_state_nxt = S_IDLE;
      w_acc_nxt   = '0;
      w_cnt_nxt   = '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          // With a one-sample window the first capture is also the last; stay in IDLE.
          if (w_cap && !w_last) begin
            w_state_nxt = S_ACCUM;
            w_acc_nxt   = w_sum;
            w_cnt_nxt   = r_cnt + 5'd1;
          end
        end
        S_ACCUM: begin
          if (w_cap) begin
            if (w_last) begin
              w_state_nxt = S_IDLE;
              w_acc_nxt   = '0;
              w_cnt_nxt   = '0;
            end else begin
              w_acc_nxt   = w_sum;
              w_cnt_nxt   = r_cnt + 5'd1;
            end
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Output register: a new result wins over a transfer in the same cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_avg       <= 16'h0000;
      r_avg_valid <= 1'b0;
    end else if (w_load) begin
      r_avg       <= w_sum[AW-1:AVG_LOG2];
      r_avg_valid <= 1'b1;
    end else if (w_xfer) begin
      r_avg_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                                 r_ovr <= 1'b0;
    else if (clr)                                 r_ovr <= 1'b0;
    else if (w_load && r_avg_valid && !out_ready) r_ovr <= 1'b1;
  end

  assign avg_o      = r_avg;
  assign avg_valid  = r_avg_valid;
  assign sample_cnt = r_cnt;
  assign overrun    = r_ovr;

`ifdef TEMP_AVG_MINMAX_EN
  logic [15:0] r_wmin, r_wmax, w_wmin, w_wmax;
  logic [15:0] r_min, r_max;

  // The first sample of a window (IDLE) restarts the running extremes.
  assign w_wmin = ((r_state == S_IDLE) || (w_sample < r_wmin)) ? w_sample : r_wmin;
  assign w_wmax = ((r_state == S_IDLE) || (w_sample > r_wmax)) ? w_sample : r_wmax;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wmin <= 16'hFFFF;
      r_wmax <= 16'h0000;
      r_min  <= 16'hFFFF;
      r_max  <= 16'h0000;
    end else if (w_cap) begin
      r_wmin <= w_wmin;
      r_wmax <= w_wmax;
      if (w_last) begin
        r_min <= w_wmin;
        r_max <= w_wmax;
      end
    end
  end

  assign min_o = r_min;
  assign max_o = r_max;
`endif

endmodule

// File: tb/tb_temp_result_avg.sv
// Bench for temp_result_avg: one AVG_LOG2=2 instance and one AVG_LOG2=0 instance, results
// checked through expected-result queues popped on every output transfer.
module tb_temp_result_avg;

  logic clk = 1'b0;
  always #50 clk = ~clk;

  logic        reset_n, clr, out_ready, valid_in;
  logic [7:0]  ib, ibf;
  logic [15:0] avg_o;
  logic        avg_valid, overrun;
  logic [4:0]  sample_cnt;

  logic        clr1, out_ready1, valid_in1;
  logic [7:0]  ib1, ibf1;
  logic [15:0] avg_o1;
  logic        avg_valid1, overrun1;
  logic [4:0]  sample_cnt1;

`ifdef TEMP_AVG_MINMAX_EN
  logic [15:0] min_o, max_o, min_o1, max_o1;
  logic [15:0] m_min, m_max, m_min_last, m_max_last;
`endif

  int          n_run  = 0;
  int          n_fail = 0;
  logic [15:0] q0[$];
  logic [15:0] q1[$];
  int unsigned m_sum;
  int          m_cnt;
  logic        m_ovr;
  logic [15:0] m_last;

  temp_result_avg #(.AVG_LOG2(2)) u_dut (
    .clk(clk), .reset_n(reset_n), .ib(ib), .ibf(ibf), .valid_in(valid_in), .clr(clr),
    .out_ready(out_ready), .avg_o(avg_o), .avg_valid(avg_valid), .sample_cnt(sample_cnt),
    .overrun(overrun)
`ifdef TEMP_AVG_MINMAX_EN
    , .min_o(min_o), .max_o(max_o)
`endif
  );

  temp_result_avg #(.AVG_LOG2(0)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .ib(ib1), .ibf(ibf1), .valid_in(valid_in1), .clr(clr1),
    .out_ready(out_ready1), .avg_o(avg_o1), .avg_valid(avg_valid1), .sample_cnt(sample_cnt1),
    .overrun(overrun1)
`ifdef TEMP_AVG_MINMAX_EN
    , .min_o(min_o1), .max_o(max_o1)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Transfer happens at the next rising edge when valid&ready are seen here.
  always @(negedge clk) begin
    if (reset_n && avg_valid && out_ready) begin
      chk("q0_pending", 32'(q0.size() > 0), 1);
      if (q0.size() > 0) chk("q0_data", avg_o, q0.pop_front());
    end
    if (reset_n && avg_valid1 && out_ready1) begin
      chk("q1_pending", 32'(q1.size() > 0), 1);
      if (q1.size() > 0) chk("q1_data", avg_o1, q1.pop_front());
    end
  end

  task automatic push0(input logic [15:0] s);
    m_sum += 32'(s);
    m_cnt++;
`ifdef TEMP_AVG_MINMAX_EN
    if (m_cnt == 1) begin
      m_min = s; m_max = s;
    end else begin
      if (s < m_min) m_min = s;
      if (s > m_max) m_max = s;
    end
`endif
    if (m_cnt == 4) begin
      if (q0.size() > 0 && !out_ready) begin
        void'(q0.pop_back());
        m_ovr = 1'b1;
      end
      m_last = 16'(m_sum >> 2);
      q0.push_back(m_last);
`ifdef TEMP_AVG_MINMAX_EN
      m_min_last = m_min; m_max_last = m_max;
`endif
      m_sum = 0;
      m_cnt = 0;
    end
  endtask

  task automatic cap0(input logic [15:0] s, input bit lat, input bit rdy_pulse);
    int pre_cnt, pre_q;
    @(posedge clk); #1;
    ib = s[15:8]; ibf = s[7:0]; valid_in = 1'b1;
    if (rdy_pulse) out_ready = 1'b1;
    pre_cnt = m_cnt;
    pre_q   = q0.size();
    push0(s);
    @(negedge clk);
    if (lat) begin
      chk("lat_pre_valid", avg_valid, 32'(pre_q > 0));
      chk("lat_pre_cnt", sample_cnt, pre_cnt);
    end
    @(posedge clk); #1;
    if (rdy_pulse) out_ready = 1'b0;
    @(negedge clk);
    if (lat) begin
      chk("lat_post_valid", avg_valid, 1);
      chk("lat_post_avg", avg_o, m_last);
      chk("lat_post_cnt", sample_cnt, m_cnt);
      chk("lat_post_ovr", overrun, m_ovr);
`ifdef TEMP_AVG_MINMAX_EN
      chk("lat_post_min", min_o, m_min_last);
      chk("lat_post_max", max_o, m_max_last);
`endif
    end
    @(posedge clk); #1 valid_in = 1'b0;
  endtask

  task automatic drain0();
    @(posedge clk); #1 out_ready = 1'b1;
    @(posedge clk); #1 out_ready = 1'b0;
    @(negedge clk);
    chk("drain_valid", avg_valid, q0.size());
  endtask

  task automatic cap1(input logic [15:0] s);
    logic [15:0] e;
    @(posedge clk); #1;
    ib1 = s[15:8]; ibf1 = s[7:0]; valid_in1 = 1'b1;
    e = s;
    q1.push_back(e);
    @(negedge clk);
    @(negedge clk);
    chk("l0_avg", avg_o1, e);
    chk("l0_valid", avg_valid1, 1);
    chk("l0_cnt", sample_cnt1, 0);
    @(posedge clk); #1 valid_in1 = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; clr = 1'b0; out_ready = 1'b0; valid_in = 1'b1; ib = 8'h12; ibf = 8'h34;
    clr1 = 1'b0; out_ready1 = 1'b1; valid_in1 = 1'b0; ib1 = 8'h00; ibf1 = 8'h00;
    m_sum = 0; m_cnt = 0; m_ovr = 1'b0; m_last = 16'h0000;
    repeat (2) @(negedge clk);
    chk("rst_avg", avg_o, 16'h0000);
    chk("rst_valid", avg_valid, 0);
    chk("rst_cnt", sample_cnt, 0);
    chk("rst_ovr", overrun, 0);
    chk("rst_avg1", avg_o1, 16'h0000);
`ifdef TEMP_AVG_MINMAX_EN
    chk("rst_min", min_o, 16'hFFFF);
    chk("rst_max", max_o, 16'h0000);
`endif
    // valid_in still high across reset release must not count
    @(posedge clk); #1 reset_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("edge_after_rst", sample_cnt, 0);
    @(posedge clk); #1 valid_in = 1'b0;

    // long valid_in pulse counts once
    out_ready = 1'b1;
    @(posedge clk); #1 ib = 8'h80; ibf = 8'h10; valid_in = 1'b1;
    push0(16'h8010);
    repeat (5) @(posedge clk);
    #1 valid_in = 1'b0;
    @(negedge clk);
    chk("hold5_cnt", sample_cnt, m_cnt);

    // clr discards partial window and a capture in its own cycle
    @(posedge clk); #1 clr = 1'b1; valid_in = 1'b1; ib = 8'h55; ibf = 8'h55;
    @(posedge clk); #1 clr = 1'b0;
    m_sum = 0; m_cnt = 0; m_ovr = 1'b0;
    @(posedge clk); #1 valid_in = 1'b0;
    @(negedge clk);
    chk("clr_cnt", sample_cnt, m_cnt);

    cap0(16'h8040, 0, 0); cap0(16'h8042, 0, 0); cap0(16'h8044, 0, 0); cap0(16'h8046, 1, 0);

    for (int w = 0; w < 3; w++)
      for (int k = 0; k < 4; k++) cap0(16'($urandom), k == 3, 0);

    // overrun: two windows with no consumer
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) cap0(16'h1000, k == 3, 0);
    for (int k = 0; k < 4; k++) cap0(16'h2000, k == 3, 0);
    @(posedge clk); #1 clr = 1'b1;
    @(posedge clk); #1 clr = 1'b0;
    m_ovr = 1'b0;
    @(negedge clk);
    chk("clr_ovr", overrun, m_ovr);
    chk("clr_keep_valid", avg_valid, q0.size());
    chk("clr_keep_avg", avg_o, m_last);
    drain0();

    // consumer ready only on the cycle the second result loads
    for (int k = 0; k < 4; k++) cap0(16'h1000, k == 3, 0);
    for (int k = 0; k < 3; k++) cap0(16'h2000, 0, 0);
    cap0(16'h2000, 1, 1);
    drain0();

    // reset mid-window with a result pending
    for (int k = 0; k < 4; k++) cap0(16'h0100, 0, 0);
    cap0(16'h0005, 0, 0); cap0(16'h0005, 0, 0);
    @(posedge clk); #1 reset_n = 1'b0;
    q0.delete(); m_sum = 0; m_cnt = 0; m_ovr = 1'b0;
    #10;
    chk("mid_rst_avg", avg_o, 16'h0000);
    chk("mid_rst_valid", avg_valid, 0);
    chk("mid_rst_cnt", sample_cnt, 0);
    chk("mid_rst_ovr", overrun, 0);
`ifdef TEMP_AVG_MINMAX_EN
    chk("mid_rst_min", min_o, 16'hFFFF);
    chk("mid_rst_max", max_o, 16'h0000);
`endif
    @(posedge clk); #1 reset_n = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) cap0(16'h0003, k == 3, 0);

    // single-sample windows
    cap1(16'hFFFF);
    cap1(16'h0001);

    repeat (3) @(negedge clk);
    chk("q0_drain", q0.size(), 0);
    chk("q1_drain", q1.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
